// File: rtl/mem2_load_unit.sv
// mem2 stage: holds the cache response across stalls, extracts
// sub-word load data, drives the forwarding bundle and writeback.
module mem2_load_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OFS_W = $clog2(DATA_WIDTH / 8),
  parameter int REG_ADDR_W = 5,
  parameter int PC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [2:0]            in_op,
  input  logic [OFS_W-1:0]      in_addr_lo,
  input  logic                  in_wreg,
  input  logic [REG_ADDR_W-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [PC_W-1:0]       in_pc,
  input  logic                  in_excp,
  input  logic                  data_ok,
  input  logic [DATA_WIDTH-1:0] cache_data,
  output logic                  stallreq,
  output logic                  fwd_valid,
  output logic                  fwd_load,
  output logic                  fwd_ready,
  output logic [REG_ADDR_W-1:0] fwd_waddr,
  output logic [DATA_WIDTH-1:0] fwd_wdata,
  output logic                  wb_valid,
  output logic                  wb_wreg,
  output logic                  wb_excp,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0] wb_wdata,
  output logic [PC_W-1:0]       wb_pc
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LBU  = 3'd2;
  localparam logic [2:0] OP_LH   = 3'd3;
  localparam logic [2:0] OP_LHU  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_LWU  = 3'd6;
  localparam logic [2:0] OP_LD   = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] ext;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] res_wdata;
  logic [31:0]           lane;
  logic                  is_load;
  logic                  mis_ofs;
  logic                  misalign;
  logic                  live;
  logic                  avail;
  logic                  capture;

  assign is_load = in_valid & (in_op != OP_NONE);

  always_comb begin
    mis_ofs = 1'b0;
    case (in_op)
      OP_LH, OP_LHU: mis_ofs = in_addr_lo[0];
      OP_LW, OP_LWU: mis_ofs = |in_addr_lo[1:0];
      OP_LD:         mis_ofs = |in_addr_lo;
      default:       mis_ofs = 1'b0;
    endcase
  end

  assign misalign = is_load & mis_ofs;
  assign live     = is_load & ~in_excp & ~misalign;
  assign avail    = data_ok | (state == S_HELD);
  assign raw      = data_ok ? cache_data : hold_q;
  assign stallreq = live & ~avail;

  // On a 32-bit datapath LWU/LD collapse onto LW naturally.
  assign lane = 32'(raw >> {in_addr_lo, 3'b000});

  always_comb begin
    ext = '0;
    case (in_op)
      OP_LB:   ext = DATA_WIDTH'($signed(lane[7:0]));
      OP_LBU:  ext = DATA_WIDTH'(lane[7:0]);
      OP_LH:   ext = DATA_WIDTH'($signed(lane[15:0]));
      OP_LHU:  ext = DATA_WIDTH'(lane[15:0]);
      OP_LW:   ext = DATA_WIDTH'($signed(lane));
      OP_LWU:  ext = DATA_WIDTH'(lane);
      OP_LD:   ext = raw;
      default: ext = '0;
    endcase
  end

  assign ld_data   = (misalign | ~avail) ? '0 : ext;
  assign res_wdata = is_load ? ld_data : in_wdata;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (live & data_ok & stall)
          state_nx = S_HELD;
        else if (live & ~data_ok)
          state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (data_ok)
          state_nx = stall ? S_HELD : S_IDLE;
      end
      S_HELD: begin
        if (~stall)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign capture = data_ok & stall &
                   (((state == S_IDLE) & live) | (state == S_WAIT));

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state  <= S_IDLE;
      hold_q <= '0;
    end else begin
      state <= state_nx;
      if (capture)
        hold_q <= cache_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wb_valid <= 1'b0;
      wb_wreg  <= 1'b0;
      wb_excp  <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      wb_pc    <= '0;
    end else if (!stall) begin
      wb_valid <= in_valid & ~(live & ~avail);
      wb_wreg  <= in_wreg & ~misalign;
      wb_excp  <= in_excp | misalign;
      wb_waddr <= in_waddr;
      wb_wdata <= res_wdata;
      wb_pc    <= in_pc;
    end
  end

  always_comb begin
    fwd_waddr = in_waddr;
    if (is_load) begin
      fwd_valid = in_wreg;
      fwd_load  = 1'b1;
      fwd_ready = avail & ~misalign;
      fwd_wdata = ld_data;
    end else begin
      fwd_valid = in_valid & in_wreg;
      fwd_load  = 1'b0;
      fwd_ready = 1'b1;
      fwd_wdata = in_wdata;
    end
  end

endmodule
